// File: rtl/acq_sequencer.sv
// acq_sequencer
//   Runs one capture cycle around the trigger controller on the ADC clock:
//   prefill the circular sample buffer, arm the trigger, capture the
//   post-trigger samples, hold the result until readout, then optionally
//   re-arm after a holdoff.
//
// Build option:
//   ACQ_AUTO_TRIGGER_EN - when defined, an ARMED timeout of AUTO_TIMEOUT
//                         cycles fires an internal trigger (same as force_trig).
//
// Ports:
//   clk, module_reset_n          ADC clock, async active-low reset
//   start, stop, auto_rearm      host control (stop has highest priority)
//   pre_count, post_count        sample counts, latched on start
//   trig_in, force_trig          trigger controller output / software trigger
//   readout_ack                  host finished reading the buffer
//   armed, trig_rst              to trigger controller (armed, manual_reset)
//   wr_en, wr_addr               sample-buffer write port
//   trig_addr                    address written on the trigger cycle
//   done, busy                   status
//   dbg_state_o                  current FSM state, for observation only
//
// Handshake: there is no valid/ready flow control here. Every control input
// is a single-cycle pulse or a level sampled at the rising clk edge; wr_en
// marks a write on each cycle it is high, and the buffer cannot stall it.
module acq_sequencer #(
  parameter int ADDR_W         = 11,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int AUTO_TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              module_reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              auto_rearm,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              trig_in,
  input  logic              force_trig,
  input  logic              readout_ack,
  output logic              armed,
  output logic              trig_rst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              done,
  output logic              busy,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_e;

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              trig_in_q;
  logic              trig_rst_q;
  logic              auto_fire;
  logic              trig_evt;

`ifdef ACQ_AUTO_TRIGGER_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(AUTO_TIMEOUT - 1);
  logic [TW-1:0] tmo_q;

  // Held at zero outside ARMED, so it is already clear on ARMED entry.
  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n)          tmo_q <= '0;
    else if (state_q == S_ARMED)  tmo_q <= tmo_q + TW'(1);
    else                          tmo_q <= '0;
  end

  assign auto_fire = (state_q == S_ARMED) && (tmo_q == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ^AUTO_TIMEOUT;
  assign auto_fire  = 1'b0;
`endif

  // Rising edge only: a trigger already asserted on ARMED entry must fall first.
  assign trig_evt = (trig_in & ~trig_in_q) | force_trig | auto_fire;

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    post_d      = post_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    trig_addr_d = trig_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pre_d   = pre_count;
          post_d  = post_count;
          cnt_d   = '0;
          state_d = S_PREFILL;
        end
      end
      S_PREFILL: begin
        cnt_d = cnt_q + ONE;
        // pre_count of zero still spends one PREFILL cycle.
        if ((pre_q == '0) || (cnt_q == pre_q - ONE)) begin
          cnt_d   = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig_evt) begin
          trig_addr_d = wr_addr_q;
          cnt_d       = '0;
          state_d     = (post_q == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == post_q - ONE) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (readout_ack) begin
          hold_d  = '0;
          state_d = auto_rearm ? S_HOLDOFF : S_IDLE;
        end
      end
      S_HOLDOFF: begin
        hold_d = hold_q + HW'(1);
        if (!auto_rearm) begin
          state_d = S_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_PREFILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle trigger.
    if (stop) begin
      state_d     = S_IDLE;
      trig_addr_d = trig_addr_q;
    end
  end

  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      post_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      trig_in_q   <= 1'b0;
      trig_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      trig_addr_q <= trig_addr_d;
      trig_in_q   <= trig_in;
      // Write pointer free-runs across acquisitions and wraps naturally.
      if (wr_en) wr_addr_q <= wr_addr_q + ONE;
      // High during the first DONE cycle only.
      trig_rst_q  <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign wr_en       = (state_q == S_PREFILL) || (state_q == S_ARMED) ||
                       (state_q == S_CAPTURE);
  assign armed       = (state_q == S_ARMED);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign wr_addr     = wr_addr_q;
  assign trig_addr   = trig_addr_q;
  assign trig_rst    = trig_rst_q;
  assign dbg_state_o = state_q;

endmodule
